// File: rtl/ddr3_fb_pkg.sv
// Frame-buffer layout shared by the DDR3 camera writer and pixel reader.
package ddr3_fb_pkg;

  localparam int FB_ADDR_W = 27;
  localparam int FB_WORD_W = 256;

  // Four rotating buffers, word addressed, 1 Mi-word stride
  localparam logic [FB_ADDR_W-1:0] FB_BUF_BASE   = 27'h1800000;
  localparam logic [FB_ADDR_W-1:0] FB_BUF_STRIDE = 27'h0100000;

  // One frame: 0x01F95000 bytes stored as 32-byte words
  localparam logic [31:0] FB_FRAME_BYTES = 32'h01F95000;
  localparam int          FB_FRAME_WORDS = 1034880;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CREDIT,
    ST_DRAIN
  } rd_state_t;

  // Word address of the first word of buffer sel
  function automatic logic [FB_ADDR_W-1:0] fb_buf_base(input logic [1:0] sel);
    return FB_BUF_BASE + FB_BUF_STRIDE * {25'd0, sel};
  endfunction

endpackage

// File: rtl/ddr3_reader_fifo.sv
// Return-data FIFO: RAM array plus a registered head word that is always
// presented when the FIFO is non-empty, so a word written into an empty
// FIFO is readable on the very next cycle.
module ddr3_reader_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 32
) (
  input  logic                   ddr3clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] mem_count_reg;
  logic             head_valid_reg;
  logic [WIDTH-1:0] head_data_reg;

  logic head_free;
  logic do_write;
  logic bypass;
  logic mem_write;
  logic refill;

  // Head slot can take a new word when empty or being popped this cycle
  assign head_free = !head_valid_reg || rd_en;
  assign do_write  = wr_en && !full;
  assign bypass    = do_write && head_free && (mem_count_reg == CNT_W'(0));
  assign mem_write = do_write && !bypass;
  assign refill    = head_free && (mem_count_reg != CNT_W'(0));

  assign count   = mem_count_reg + CNT_W'(head_valid_reg);
  assign empty   = !head_valid_reg;
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_data = head_data_reg;

  // RAM write port
  always_ff @(posedge ddr3clk) begin
    if (mem_write) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Registered RAM read into the head word, or direct load when RAM is empty
  always_ff @(posedge ddr3clk) begin
    if (refill) begin
      head_data_reg <= mem[rd_ptr_reg];
    end else if (bypass) begin
      head_data_reg <= wr_data;
    end
  end

  // Pointers, occupancy and head-valid flag
  always_ff @(posedge ddr3clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_count_reg  <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (mem_write) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (refill) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      mem_count_reg <= mem_count_reg + CNT_W'(mem_write) - CNT_W'(refill);
      if (refill || bypass) begin
        head_valid_reg <= 1'b1;
      end else if (rd_en) begin
        head_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ddr3_pixel_reader_burst.sv
// Reads one frame from a DDR3 frame buffer with Avalon-MM burst reads,
// buffers the returned words and unpacks them into a valid/ready pixel
// stream. Bursts are only issued when the FIFO has room for every word
// already requested plus the new burst, so the FIFO never overflows.
module ddr3_pixel_reader_burst
  import ddr3_fb_pkg::*;
#(
  parameter int out_width   = 32,
  parameter int burst_len   = 8,
  parameter int fifo_depth  = 32,
  parameter int frame_words = FB_FRAME_WORDS
) (
  input  logic                 ddr3clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic [1:0]           buf_sel,
  output logic [26:0]          read_address,
  output logic                 read,
  output logic [3:0]           burstcount,
  input  logic                 waitrequest,
  input  logic [255:0]         readdata,
  input  logic                 readdatavalid,
  output logic [out_width-1:0] pixel,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 rd_error
);

  localparam int PIX_PER_WORD = FB_WORD_W / out_width;
  localparam int NUM_BURSTS   = frame_words / burst_len;
  localparam int CNT_W        = $clog2(fifo_depth) + 1;
  localparam int BCNT_W       = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int PIX_W        = $clog2(PIX_PER_WORD + 1);

  rd_state_t state_reg;
  rd_state_t state_next;

  logic [BCNT_W-1:0]    burst_cnt_reg;
  logic [CNT_W-1:0]     pending_reg;
  logic [FB_WORD_W-1:0] word_reg;
  logic [PIX_W-1:0]     pix_left_reg;

  logic [FB_WORD_W-1:0] fifo_rd_data;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;

  logic           burst_accept;
  logic           last_burst;
  logic [CNT_W:0] credit_sum;
  logic           credit_ok;
  logic           drain_done;
  logic           beat_ok;
  logic           beat_spurious;
  logic           beat_overflow;
  logic           pix_accept;
  logic           pix_last;
  logic           word_load;

  assign burstcount = 4'(burst_len);

  assign burst_accept = (state_reg == ST_ISSUE) && !waitrequest;
  assign last_burst   = (burst_cnt_reg == BCNT_W'(NUM_BURSTS - 1));

  // Room check counts words already in the FIFO plus every word still owed
  assign credit_sum = {1'b0, fifo_count} + {1'b0, pending_reg} + (CNT_W + 1)'(burst_len);
  assign credit_ok  = (credit_sum <= (CNT_W + 1)'(fifo_depth));

  assign drain_done = (pending_reg == CNT_W'(0)) && fifo_empty && (pix_left_reg == PIX_W'(0));

  // Beats are only legal while a request is outstanding
  assign beat_ok       = readdatavalid && (pending_reg != CNT_W'(0));
  assign beat_spurious = readdatavalid && (pending_reg == CNT_W'(0));
  assign beat_overflow = beat_ok && fifo_full;

  assign pixel       = word_reg[out_width-1:0];
  assign pixel_valid = (pix_left_reg != PIX_W'(0));
  assign pix_accept  = pixel_valid && pixel_ready;
  assign pix_last    = pix_accept && (pix_left_reg == PIX_W'(1));
  // Reload on the same edge the last pixel leaves, so the stream has no gap
  assign word_load   = !fifo_empty && ((pix_left_reg == PIX_W'(0)) || pix_last);

  ddr3_reader_fifo #(
    .WIDTH (FB_WORD_W),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .ddr3clk (ddr3clk),
    .reset   (reset),
    .wr_en   (beat_ok),
    .wr_data (readdata),
    .rd_en   (word_load),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // State register
  always_ff @(posedge ddr3clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and Avalon/frame control outputs
  always_comb begin
    state_next = state_reg;
    read       = 1'b0;
    frame_busy = 1'b1;
    frame_done = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        frame_busy = 1'b0;
        if (frame_start) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        read = 1'b1;
        if (!waitrequest) begin
          state_next = last_burst ? ST_DRAIN : ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (credit_ok) begin
          state_next = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          frame_done = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Burst address and burst counter; address only moves on acceptance
  always_ff @(posedge ddr3clk or posedge reset) begin
    if (reset) begin
      read_address  <= '0;
      burst_cnt_reg <= '0;
    end else if ((state_reg == ST_IDLE) && frame_start) begin
      read_address  <= fb_buf_base(buf_sel);
      burst_cnt_reg <= '0;
    end else if (burst_accept && !last_burst) begin
      read_address  <= read_address + 27'(burst_len);
      burst_cnt_reg <= burst_cnt_reg + BCNT_W'(1);
    end
  end

  // Outstanding-word tracking and sticky error flag
  always_ff @(posedge ddr3clk or posedge reset) begin
    if (reset) begin
      pending_reg <= '0;
      rd_error    <= 1'b0;
    end else begin
      pending_reg <= pending_reg
                     + (burst_accept ? CNT_W'(burst_len) : CNT_W'(0))
                     - (beat_ok ? CNT_W'(1) : CNT_W'(0));
      if (beat_spurious || beat_overflow) begin
        rd_error <= 1'b1;
      end
    end
  end

  // Unpacker: holds one word and shifts out one pixel per accepted transfer
  always_ff @(posedge ddr3clk or posedge reset) begin
    if (reset) begin
      word_reg     <= '0;
      pix_left_reg <= '0;
    end else if (word_load) begin
      word_reg     <= fifo_rd_data;
      pix_left_reg <= PIX_W'(PIX_PER_WORD);
    end else if (pix_accept) begin
      word_reg     <= word_reg >> out_width;
      pix_left_reg <= pix_left_reg - PIX_W'(1);
    end
  end

endmodule

// File: tb/tb_ddr3_pixel_reader_burst.sv
// Directed bench for ddr3_pixel_reader_burst with a small Avalon memory
// model and a pixel consumer. One line is printed per frame.
module tb_ddr3_pixel_reader_burst;

  localparam int OUT_W  = 32;
  localparam int BURST  = 8;
  localparam int DEPTH  = 32;
  localparam int FWORDS = 32;
  localparam int PPW    = 256 / OUT_W;
  localparam int NPIX   = FWORDS * PPW;
  localparam int NBURST = FWORDS / BURST;

  logic         ddr3clk = 1'b0;
  logic         reset = 1'b1;
  logic         frame_start = 1'b0;
  logic [1:0]   buf_sel = 2'd0;
  logic [26:0]  read_address;
  logic         read;
  logic [3:0]   burstcount;
  logic         waitrequest = 1'b0;
  logic [255:0] readdata = '0;
  logic         readdatavalid = 1'b0;
  logic [31:0]  pixel;
  logic         pixel_valid;
  logic         pixel_ready = 1'b0;
  logic         frame_busy;
  logic         frame_done;
  logic         rd_error;

  ddr3_pixel_reader_burst #(
    .out_width   (OUT_W),
    .burst_len   (BURST),
    .fifo_depth  (DEPTH),
    .frame_words (FWORDS)
  ) dut (
    .ddr3clk       (ddr3clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .buf_sel       (buf_sel),
    .read_address  (read_address),
    .read          (read),
    .burstcount    (burstcount),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .pixel         (pixel),
    .pixel_valid   (pixel_valid),
    .pixel_ready   (pixel_ready),
    .frame_busy    (frame_busy),
    .frame_done    (frame_done),
    .rd_error      (rd_error)
  );

  always #5 ddr3clk = ~ddr3clk;

  int cyc = 0;
  always @(posedge ddr3clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory content: pixel k of word a is {a[23:0], k}
  function automatic logic [255:0] mem_word(input logic [26:0] a);
    logic [255:0] w;
    for (int k = 0; k < PPW; k++) w[k*32 +: 32] = {a[23:0], 8'(k)};
    return w;
  endfunction

  function automatic logic [31:0] exp_pixel(input logic [26:0] base, input int idx);
    logic [26:0] a;
    a = base + 27'(idx / PPW);
    return {a[23:0], 8'(idx % PPW)};
  endfunction

  // ---------------- memory model ----------------
  int          lat_min = 5;
  int          lat_max = 5;
  int          n_stall = 0;
  bit          spur_req = 1'b0;
  logic [26:0] exp_base = '0;
  int          burst_idx = 0;
  int          first_rdv_cyc = -1;
  int          last_rdy = 0;
  int          beat_rdy[$];
  logic [26:0] beat_addr[$];

  initial begin : mem_model
    int          stall_cnt;
    int          lat;
    int          r;
    logic [26:0] stall_addr;
    stall_cnt  = 0;
    stall_addr = '0;
    forever begin
      @(negedge ddr3clk);
      readdatavalid = 1'b0;
      waitrequest   = 1'b0;
      if (reset) begin
        beat_rdy.delete();
        beat_addr.delete();
        stall_cnt = 0;
      end else begin
        if (read) begin
          if (stall_cnt < n_stall) begin
            if (stall_cnt == 0) stall_addr = read_address;
            else chk("addr_stable", read_address, stall_addr);
            waitrequest = 1'b1;
            stall_cnt++;
          end else begin
            if (stall_cnt > 0) chk("addr_stable", read_address, stall_addr);
            chk("burst_addr", read_address, exp_base + 27'(burst_idx * BURST));
            chk("burstcount", burstcount, BURST);
            burst_idx++;
            stall_cnt = 0;
            lat = $urandom_range(lat_max, lat_min);
            for (int i = 0; i < BURST; i++) begin
              r = cyc + lat + i;
              if (r <= last_rdy) r = last_rdy + 1;
              last_rdy = r;
              beat_rdy.push_back(r);
              beat_addr.push_back(read_address + 27'(i));
            end
          end
        end
        if (spur_req) begin
          readdatavalid = 1'b1;
          readdata      = '1;
          spur_req      = 1'b0;
        end else if (beat_rdy.size() > 0 && beat_rdy[0] <= cyc) begin
          readdatavalid = 1'b1;
          readdata      = mem_word(beat_addr[0]);
          if (first_rdv_cyc < 0) first_rdv_cyc = cyc;
          void'(beat_rdy.pop_front());
          void'(beat_addr.pop_front());
        end
      end
    end
  end

  // ---------------- pixel consumer ----------------
  int          ready_mode = 0;
  bit          hold_release = 1'b0;
  bit          cons_en = 1'b0;
  int          pix_idx = 0;
  int          done_cnt = 0;
  int          first_pv_cyc = -1;
  int          first_acc_cyc = 0;
  int          last_acc_cyc = 0;

  initial begin : consumer
    bit          prev_stall;
    logic [31:0] prev_pix;
    prev_stall = 1'b0;
    prev_pix   = '0;
    forever begin
      @(negedge ddr3clk);
      if (reset || !cons_en) begin
        pixel_ready = 1'b0;
        prev_stall  = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", pixel_valid, 1'b1);
          chk("hold_pixel", pixel, prev_pix);
        end
        case (ready_mode)
          0:       pixel_ready = 1'b1;
          1:       pixel_ready = (pix_idx == 0) || hold_release;
          default: pixel_ready = 1'($urandom_range(1, 0));
        endcase
        if (pixel_valid && first_pv_cyc < 0) first_pv_cyc = cyc;
        if (frame_done) begin
          done_cnt++;
          chk("done_after_last", pix_idx, NPIX);
        end
        if (pixel_valid && pixel_ready) begin
          if (pix_idx < NPIX) chk("pixel", pixel, exp_pixel(exp_base, pix_idx));
          else chk("pixel_overrun", pix_idx, NPIX - 1);
          if (pix_idx == 0) first_acc_cyc = cyc;
          last_acc_cyc = cyc;
          pix_idx++;
        end
        prev_stall = pixel_valid && !pixel_ready;
        prev_pix   = pixel;
      end
    end
  end

  // ---------------- main sequence helpers ----------------
  task automatic start_frame(input logic [1:0] sel, input logic [26:0] base);
    exp_base      = base;
    burst_idx     = 0;
    pix_idx       = 0;
    done_cnt      = 0;
    first_pv_cyc  = -1;
    first_rdv_cyc = -1;
    last_rdy      = 0;
    cons_en       = 1'b1;
    frame_start   = 1'b1;
    buf_sel       = sel;
    @(negedge ddr3clk);
    frame_start = 1'b0;
    chk("read_rise", read, 1'b1);
    chk("busy_set", frame_busy, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge ddr3clk);
      n++;
    end
    chk({tag, "_timeout"}, (done_cnt > 0), 1'b1);
    repeat (20) @(negedge ddr3clk);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_pixels"}, pix_idx, NPIX);
    chk({tag, "_bursts"}, burst_idx, NBURST);
    chk({tag, "_busy_clr"}, frame_busy, 1'b0);
    chk({tag, "_rd_error"}, rd_error, 1'b0);
    $display("frame %s: base=0x%0h bursts=%0d pixels=%0d done=%0d", tag, exp_base, burst_idx, pix_idx, done_cnt);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_read"}, read, 1'b0);
    chk({tag, "_addr"}, read_address, 27'h0);
    chk({tag, "_burstcount"}, burstcount, BURST);
    chk({tag, "_pixel"}, pixel, 32'h0);
    chk({tag, "_pixel_valid"}, pixel_valid, 1'b0);
    chk({tag, "_busy"}, frame_busy, 1'b0);
    chk({tag, "_done"}, frame_done, 1'b0);
    chk({tag, "_rd_error"}, rd_error, 1'b0);
  endtask

  logic [1:0]  rnd_sel  [3] = '{2'd1, 2'd3, 2'd0};
  logic [26:0] rnd_base [3] = '{27'h1900000, 27'h1B00000, 27'h1800000};

  initial begin : main
    int n;
    repeat (3) @(negedge ddr3clk);
    chk_reset_state("reset");
    reset = 1'b0;
    repeat (2) @(negedge ddr3clk);

    // Basic frame from buffer 2
    ready_mode = 0;
    start_frame(2'd2, 27'h1A00000);
    wait_done("basic");
    chk("latency_rdv_to_valid", first_pv_cyc - first_rdv_cyc, 2);
    chk("throughput_span", last_acc_cyc - first_acc_cyc, NPIX - 1);

    // Backpressure after the first pixel
    ready_mode   = 1;
    hold_release = 1'b0;
    start_frame(2'd3, 27'h1B00000);
    n = 0;
    while (burst_idx < NBURST && n < 500) begin
      @(negedge ddr3clk);
      n++;
    end
    repeat (60) @(negedge ddr3clk);
    chk("bp_bursts", burst_idx, NBURST);
    chk("bp_one_pixel", pix_idx, 1);
    chk("bp_valid", pixel_valid, 1'b1);
    chk("bp_busy", frame_busy, 1'b1);
    chk("bp_no_done", done_cnt, 0);
    chk("bp_rd_error", rd_error, 1'b0);
    hold_release = 1'b1;
    wait_done("backpressure");
    hold_release = 1'b0;

    // waitrequest held 3 cycles on every burst
    ready_mode = 0;
    n_stall    = 3;
    start_frame(2'd0, 27'h1800000);
    wait_done("waitrequest");
    n_stall = 0;

    // frame_start while busy must be ignored
    start_frame(2'd1, 27'h1900000);
    repeat (10) @(negedge ddr3clk);
    frame_start = 1'b1;
    buf_sel     = 2'd3;
    @(negedge ddr3clk);
    frame_start = 1'b0;
    wait_done("ignored_start");

    // Random backpressure and return latency
    ready_mode = 2;
    lat_min    = 2;
    lat_max    = 20;
    for (int f = 0; f < 3; f++) begin
      start_frame(rnd_sel[f], rnd_base[f]);
      wait_done("random");
    end
    lat_min = 5;
    lat_max = 5;

    // Mid-frame reset, then a spurious beat
    ready_mode = 0;
    start_frame(2'd2, 27'h1A00000);
    repeat (15) @(negedge ddr3clk);
    cons_en = 1'b0;
    @(negedge ddr3clk);
    reset = 1'b1;
    @(negedge ddr3clk);
    chk_reset_state("midreset");
    reset = 1'b0;
    @(negedge ddr3clk);
    spur_req = 1'b1;
    repeat (3) @(negedge ddr3clk);
    chk("spurious_rd_error", rd_error, 1'b1);
    chk("spurious_idle", frame_busy, 1'b0);
    $display("frame reset: spurious beat rd_error=%0d", rd_error);
    reset = 1'b1;
    @(negedge ddr3clk);
    reset = 1'b0;
    @(negedge ddr3clk);
    chk("rd_error_cleared", rd_error, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
